// File: rtl/stx_n_cntr_mon.sv
// stx_n_cntr_mon: measures the period of an N-counter output (div_in) in clk
// cycles, compares it with the expected modulus, and reports lock, per-period
// mismatch, timeout and a saturating error count.
module stx_n_cntr_mon #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TO_MULT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        div_in,
    input  logic [31:0] modulus,
    output logic [31:0] measured,
    output logic        meas_valid,
    output logic        locked,
    output logic        mismatch,
    output logic        timeout,
    output logic        cfg_err,
    output logic [15:0] err_count
);

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned LIM_W   = 34;
    localparam int unsigned MATCH_W = 8;
    localparam int unsigned ERR_W   = 16;

    localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [ERR_W-1:0]   ERR_MAX  = '1;
    localparam logic [CNT_W-1:0]   MOD_MIN  = CNT_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    state_e             state_q,      state_d;
    logic               div_q,        div_d;
    logic [CNT_W-1:0]   mod_r_q,      mod_r_d;
    logic [CNT_W-1:0]   per_cnt_q,    per_cnt_d;
    logic [CNT_W-1:0]   measured_q,   measured_d;
    logic [MATCH_W-1:0] match_cnt_q,  match_cnt_d;
    logic               meas_valid_q, meas_valid_d;
    logic               locked_q,     locked_d;
    logic               mismatch_q,   mismatch_d;
    logic               timeout_q,    timeout_d;
    logic               cfg_err_q,    cfg_err_d;
    logic [ERR_W-1:0]   err_count_q,  err_count_d;

    logic               rise_c;
    logic [LIM_W-1:0]   limit_c;
    logic               limit_hit_c;
    logic [MATCH_W-1:0] match_inc_c;
    logic               err_evt_c;

    // Edge detect, timeout limit (34-bit so it cannot wrap) and saturating match increment
    always_comb begin
        rise_c      = div_in & ~div_q;
        limit_c     = LIM_W'(TO_MULT) * LIM_W'(mod_r_q);
        limit_hit_c = ({2'b00, per_cnt_q} >= limit_c);
        match_inc_c = (match_cnt_q >= LOCK_TGT) ? LOCK_TGT : (match_cnt_q + MATCH_W'(1));
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            div_q        <= 1'b0;
            mod_r_q      <= '0;
            per_cnt_q    <= '0;
            measured_q   <= '0;
            match_cnt_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            mismatch_q   <= 1'b0;
            timeout_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            mod_r_q      <= mod_r_d;
            per_cnt_q    <= per_cnt_d;
            measured_q   <= measured_d;
            match_cnt_q  <= match_cnt_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            mismatch_q   <= mismatch_d;
            timeout_q    <= timeout_d;
            cfg_err_q    <= cfg_err_d;
            err_count_q  <= err_count_d;
        end
    end

    // Next-state: sync to first edge, then measure every period and track lock
    always_comb begin
        state_d      = state_q;
        div_d        = div_in;
        mod_r_d      = mod_r_q;
        per_cnt_d    = per_cnt_q;
        measured_d   = measured_q;
        match_cnt_d  = match_cnt_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        mismatch_d   = 1'b0;
        timeout_d    = 1'b0;
        cfg_err_d    = cfg_err_q;
        err_count_d  = err_count_q;
        err_evt_c    = 1'b0;

        if (!enable) begin
            state_d     = ST_IDLE;
            locked_d    = 1'b0;
            match_cnt_d = '0;
            per_cnt_d   = '0;
            cfg_err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mod_r_d = modulus;
                    if (modulus >= MOD_MIN) begin
                        cfg_err_d = 1'b0;
                        state_d   = ST_SYNC;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (rise_c) begin
                        per_cnt_d = CNT_W'(1);
                        state_d   = ST_MEASURE;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (rise_c) begin
                        measured_d   = per_cnt_q;
                        meas_valid_d = 1'b1;
                        per_cnt_d    = CNT_W'(1);
                        if (per_cnt_q == mod_r_q) begin
                            match_cnt_d = match_inc_c;
                            if (match_inc_c == LOCK_TGT) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            mismatch_d  = 1'b1;
                            err_evt_c   = 1'b1;
                            match_cnt_d = '0;
                            locked_d    = 1'b0;
                            state_d     = ST_MEASURE;
                        end
                    end else if (limit_hit_c) begin
                        timeout_d   = 1'b1;
                        err_evt_c   = 1'b1;
                        match_cnt_d = '0;
                        locked_d    = 1'b0;
                        per_cnt_d   = '0;
                        state_d     = ST_SYNC;
                    end else if (per_cnt_q != CNT_MAX) begin
                        per_cnt_d = per_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (err_evt_c && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    assign measured   = measured_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign mismatch   = mismatch_q;
    assign timeout    = timeout_q;
    assign cfg_err    = cfg_err_q;
    assign err_count  = err_count_q;

endmodule
